// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - register file write-port arbiter with long-latency scoreboard
//
// Shares the register file's single write port between the in-order writeback
// stage (pipe) and the long-latency unit (long). Each requester has a
// one-entry buffer. A round-robin arbiter grants one buffer per cycle into a
// registered write port. An optional scoreboard tracks outstanding
// long-latency destinations so decode can stall on RAW hazards.
//
// Optional feature macro: REGFILE_SCOREBOARD_EN (defined = scoreboard present;
// undefined = issue_accept 1, query_busy_* 0, pending_count 0, scoreboard_error 0).
//
// Ports:
//   clock, resetn                      clock, synchronous active-low reset
//   pipe_valid/ready/address/strobe/data   writeback write request
//   long_valid/ready/address/strobe/data   long-latency write request
//   issue_valid, issue_address, issue_accept  long-latency issue into scoreboard
//   query_address_1/2, query_busy_1/2      decode source hazard query
//   rf_write_enabled/address/strobe/data   registered register file write port
//   pending_count, scoreboard_error        scoreboard status

module regfile_write_scheduler #(
    parameter int MAX_PENDING = 4
) (
    input  logic        clock,
    input  logic        resetn,

    input  logic        pipe_valid,
    output logic        pipe_ready,
    input  logic [4:0]  pipe_address,
    input  logic [3:0]  pipe_strobe,
    input  logic [31:0] pipe_data,

    input  logic        long_valid,
    output logic        long_ready,
    input  logic [4:0]  long_address,
    input  logic [3:0]  long_strobe,
    input  logic [31:0] long_data,

    input  logic        issue_valid,
    input  logic [4:0]  issue_address,
    output logic        issue_accept,

    input  logic [4:0]  query_address_1,
    input  logic [4:0]  query_address_2,
    output logic        query_busy_1,
    output logic        query_busy_2,

    output logic        rf_write_enabled,
    output logic [4:0]  rf_write_address,
    output logic [3:0]  rf_write_strobe,
    output logic [31:0] rf_write_data,

    output logic [2:0]  pending_count,
    output logic        scoreboard_error
);

    // Request buffers
    logic        pipe_full_q, pipe_full_d;
    logic [4:0]  pipe_addr_q, pipe_addr_d;
    logic [3:0]  pipe_strb_q, pipe_strb_d;
    logic [31:0] pipe_data_q, pipe_data_d;

    logic        long_full_q, long_full_d;
    logic [4:0]  long_addr_q, long_addr_d;
    logic [3:0]  long_strb_q, long_strb_d;
    logic [31:0] long_data_q, long_data_d;

    // 1 = long was granted most recently; resets to 1 so pipe wins the first tie
    logic        last_long_q, last_long_d;

    // Registered write port
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [3:0]  rf_strb_q, rf_strb_d;
    logic [31:0] rf_data_q, rf_data_d;
    logic        rf_src_long_q, rf_src_long_d;

    logic grant_pipe;
    logic grant_long;
    logic pipe_accept;
    logic long_accept;

    always_comb begin
        grant_pipe  = pipe_full_q && (!long_full_q || last_long_q);
        grant_long  = long_full_q && !grant_pipe;
        pipe_ready  = !pipe_full_q || grant_pipe;
        long_ready  = !long_full_q || grant_long;
        pipe_accept = pipe_valid && pipe_ready;
        long_accept = long_valid && long_ready;
    end

    always_comb begin
        pipe_full_d = pipe_full_q;
        pipe_addr_d = pipe_addr_q;
        pipe_strb_d = pipe_strb_q;
        pipe_data_d = pipe_data_q;
        long_full_d = long_full_q;
        long_addr_d = long_addr_q;
        long_strb_d = long_strb_q;
        long_data_d = long_data_q;

        // Grant drains the buffer; a same-cycle accept refills it
        if (grant_pipe) begin
            pipe_full_d = 1'b0;
        end
        if (pipe_accept) begin
            pipe_full_d = 1'b1;
            pipe_addr_d = pipe_address;
            pipe_strb_d = pipe_strobe;
            pipe_data_d = pipe_data;
        end
        if (grant_long) begin
            long_full_d = 1'b0;
        end
        if (long_accept) begin
            long_full_d = 1'b1;
            long_addr_d = long_address;
            long_strb_d = long_strobe;
            long_data_d = long_data;
        end
    end

    always_comb begin
        last_long_d   = last_long_q;
        rf_we_d       = 1'b0;
        rf_addr_d     = rf_addr_q;
        rf_strb_d     = rf_strb_q;
        rf_data_d     = rf_data_q;
        rf_src_long_d = rf_src_long_q;

        // Address 0 entries still take the port for a cycle but never write
        if (grant_pipe) begin
            rf_we_d       = (pipe_addr_q != 5'd0);
            rf_addr_d     = pipe_addr_q;
            rf_strb_d     = pipe_strb_q;
            rf_data_d     = pipe_data_q;
            rf_src_long_d = 1'b0;
            last_long_d   = 1'b0;
        end else if (grant_long) begin
            rf_we_d       = (long_addr_q != 5'd0);
            rf_addr_d     = long_addr_q;
            rf_strb_d     = long_strb_q;
            rf_data_d     = long_data_q;
            rf_src_long_d = 1'b1;
            last_long_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pipe_full_q   <= 1'b0;
            pipe_addr_q   <= 5'd0;
            pipe_strb_q   <= 4'd0;
            pipe_data_q   <= 32'd0;
            long_full_q   <= 1'b0;
            long_addr_q   <= 5'd0;
            long_strb_q   <= 4'd0;
            long_data_q   <= 32'd0;
            last_long_q   <= 1'b1;
            rf_we_q       <= 1'b0;
            rf_addr_q     <= 5'd0;
            rf_strb_q     <= 4'd0;
            rf_data_q     <= 32'd0;
            rf_src_long_q <= 1'b0;
        end else begin
            pipe_full_q   <= pipe_full_d;
            pipe_addr_q   <= pipe_addr_d;
            pipe_strb_q   <= pipe_strb_d;
            pipe_data_q   <= pipe_data_d;
            long_full_q   <= long_full_d;
            long_addr_q   <= long_addr_d;
            long_strb_q   <= long_strb_d;
            long_data_q   <= long_data_d;
            last_long_q   <= last_long_d;
            rf_we_q       <= rf_we_d;
            rf_addr_q     <= rf_addr_d;
            rf_strb_q     <= rf_strb_d;
            rf_data_q     <= rf_data_d;
            rf_src_long_q <= rf_src_long_d;
        end
    end

    assign rf_write_enabled = rf_we_q;
    assign rf_write_address = rf_addr_q;
    assign rf_write_strobe  = rf_strb_q;
    assign rf_write_data    = rf_data_q;

`ifdef REGFILE_SCOREBOARD_EN
    // Bit 0 is held at 0 so address 0 never reads busy
    logic [31:0] busy_q, busy_d;
    logic [2:0]  pending_q, pending_d;
    logic        err_q, err_d;

    logic issue_set;
    logic commit_clr;
    logic clr_hit;

    always_comb begin
        // Uses the registered busy bit, so a register clearing this cycle still blocks re-issue
        issue_accept = (issue_address == 5'd0) ||
                       (!busy_q[issue_address] && (pending_q != 3'(MAX_PENDING)));
        issue_set    = issue_valid && issue_accept && (issue_address != 5'd0);
        // Clear on the same edge the register file commits the long write
        commit_clr   = rf_we_q && rf_src_long_q;
        clr_hit      = commit_clr && busy_q[rf_addr_q];
        query_busy_1 = busy_q[query_address_1];
        query_busy_2 = busy_q[query_address_2];
    end

    always_comb begin
        busy_d    = busy_q;
        pending_d = pending_q;
        err_d     = err_q;
        if (commit_clr) begin
            if (clr_hit) begin
                busy_d[rf_addr_q] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (issue_set) begin
            busy_d[issue_address] = 1'b1;
        end
        busy_d[0] = 1'b0;
        pending_d = pending_q + {2'b00, issue_set} - {2'b00, clr_hit};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            busy_q    <= 32'd0;
            pending_q <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending_count    = pending_q;
    assign scoreboard_error = err_q;
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_address, query_address_1,
                                query_address_2, rf_src_long_q};

    assign issue_accept     = 1'b1;
    assign query_busy_1     = 1'b0;
    assign query_busy_2     = 1'b0;
    assign pending_count    = 3'd0;
    assign scoreboard_error = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - directed self-checking bench for regfile_write_scheduler

module tb_regfile_write_scheduler;

`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        pipe_valid, pipe_ready;
    logic [4:0]  pipe_address;
    logic [3:0]  pipe_strobe;
    logic [31:0] pipe_data;
    logic        long_valid, long_ready;
    logic [4:0]  long_address;
    logic [3:0]  long_strobe;
    logic [31:0] long_data;
    logic        issue_valid;
    logic [4:0]  issue_address;
    logic        issue_accept;
    logic [4:0]  query_address_1, query_address_2;
    logic        query_busy_1, query_busy_2;
    logic        rf_write_enabled;
    logic [4:0]  rf_write_address;
    logic [3:0]  rf_write_strobe;
    logic [31:0] rf_write_data;
    logic [2:0]  pending_count;
    logic        scoreboard_error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_write_scheduler #(.MAX_PENDING(4)) dut (
        .clock(clock), .resetn(resetn),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_address(pipe_address),
        .pipe_strobe(pipe_strobe), .pipe_data(pipe_data),
        .long_valid(long_valid), .long_ready(long_ready), .long_address(long_address),
        .long_strobe(long_strobe), .long_data(long_data),
        .issue_valid(issue_valid), .issue_address(issue_address), .issue_accept(issue_accept),
        .query_address_1(query_address_1), .query_address_2(query_address_2),
        .query_busy_1(query_busy_1), .query_busy_2(query_busy_2),
        .rf_write_enabled(rf_write_enabled), .rf_write_address(rf_write_address),
        .rf_write_strobe(rf_write_strobe), .rf_write_data(rf_write_data),
        .pending_count(pending_count), .scoreboard_error(scoreboard_error)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        pipe_valid = 0; pipe_address = 0; pipe_strobe = 0; pipe_data = 0;
        long_valid = 0; long_address = 0; long_strobe = 0; long_data = 0;
        issue_valid = 0; issue_address = 0;
        query_address_1 = 0; query_address_2 = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        clear_inputs();
        tick();
        resetn = 1;
        #1;
    endtask

    initial begin
        int pidx;
        int lidx;
        logic hp;
        logic hl;

        resetn = 0;
        clear_inputs();
        tick();
        tick();
        resetn = 1;
        #1;

        // Reset state
        check_eq("rst_we",    rf_write_enabled, 0);
        check_eq("rst_addr",  rf_write_address, 0);
        check_eq("rst_strb",  rf_write_strobe, 0);
        check_eq("rst_data",  rf_write_data, 0);
        check_eq("rst_pend",  pending_count, 0);
        check_eq("rst_err",   scoreboard_error, 0);
        check_eq("rst_pready", pipe_ready, 1);
        check_eq("rst_lready", long_ready, 1);

        // Single uncontended pipe write
        pipe_valid = 1; pipe_address = 5; pipe_strobe = 4'hf; pipe_data = 32'h1234_5678;
        #1;
        check_eq("t1_pready0", pipe_ready, 1);
        tick();
        pipe_valid = 0;
        #1;
        check_eq("t1_we_t0", rf_write_enabled, 0);
        check_eq("t1_pready1", pipe_ready, 1);
        tick();
        check_eq("t1_we",   rf_write_enabled, 1);
        check_eq("t1_addr", rf_write_address, 5);
        check_eq("t1_strb", rf_write_strobe, 4'hf);
        check_eq("t1_data", rf_write_data, 32'h1234_5678);
        tick();
        check_eq("t1_we_off", rf_write_enabled, 0);
        check_eq("t1_addr_hold", rf_write_address, 5);

        // Both streaming: pipe first after reset, then alternate
        do_reset();
        pidx = 0;
        lidx = 0;
        for (int k = 0; k < 10; k++) begin
            pipe_valid = 1; pipe_address = 3; pipe_strobe = 4'b0011;
            pipe_data = 32'hA000_0000 + 32'(pidx);
            long_valid = 1; long_address = 7; long_strobe = 4'b1100;
            long_data = 32'hB000_0000 + 32'(lidx);
            #1;
            check_eq($sformatf("rr_pready%0d", k), pipe_ready, (k == 0) || (k % 2 == 1));
            check_eq($sformatf("rr_lready%0d", k), long_ready, (k == 0) || (k % 2 == 0));
            if (k < 2) begin
                check_eq($sformatf("rr_we%0d", k), rf_write_enabled, 0);
            end else begin
                check_eq($sformatf("rr_we%0d", k), rf_write_enabled, 1);
                if (k % 2 == 0) begin
                    check_eq($sformatf("rr_addr%0d", k), rf_write_address, 3);
                    check_eq($sformatf("rr_data%0d", k), rf_write_data,
                             32'hA000_0000 + 32'((k - 2) / 2));
                end else begin
                    check_eq($sformatf("rr_addr%0d", k), rf_write_address, 7);
                    check_eq($sformatf("rr_data%0d", k), rf_write_data,
                             32'hB000_0000 + 32'((k - 3) / 2));
                end
            end
            hp = pipe_ready;
            hl = long_ready;
            tick();
            if (hp) pidx++;
            if (hl) lidx++;
        end
        pipe_valid = 0;
        long_valid = 0;
        tick(); tick(); tick();

        // Issue and clear of a long-latency destination
        do_reset();
        issue_valid = 1; issue_address = 9; query_address_1 = 9; query_address_2 = 0;
        #1;
        check_eq("sb_acc9", issue_accept, 1);
        check_eq("sb_busy9_pre", query_busy_1, 0);
        tick();
        issue_valid = 0;
        #1;
        check_eq("sb_busy9", query_busy_1, SB);
        check_eq("sb_busy0", query_busy_2, 0);
        check_eq("sb_pend1", pending_count, SB ? 1 : 0);
        long_valid = 1; long_address = 9; long_strobe = 4'hf; long_data = 32'hCAFE_0009;
        tick();
        long_valid = 0;
        #1;
        check_eq("sb_busy9_acc", query_busy_1, SB);
        tick();
        check_eq("sb_we9", rf_write_enabled, 1);
        check_eq("sb_addr9", rf_write_address, 9);
        check_eq("sb_busy9_we", query_busy_1, SB);
        tick();
        check_eq("sb_busy9_clr", query_busy_1, 0);
        check_eq("sb_pend0", pending_count, 0);
        check_eq("sb_err0", scoreboard_error, 0);

        // Fill to MAX_PENDING, then refused issues
        do_reset();
        for (int a = 1; a <= 4; a++) begin
            issue_valid = 1; issue_address = 5'(a);
            #1;
            check_eq($sformatf("full_acc%0d", a), issue_accept, 1);
            tick();
        end
        issue_address = 6;
        #1;
        check_eq("full_pend4", pending_count, SB ? 4 : 0);
        check_eq("full_acc6", issue_accept, !SB);
        issue_address = 2;
        #1;
        check_eq("full_acc2", issue_accept, !SB);
        issue_address = 0;
        #1;
        check_eq("full_acc0", issue_accept, 1);
        tick();
        issue_valid = 0;
        #1;
        check_eq("full_pend_hold", pending_count, SB ? 4 : 0);

        // Address 0 writes, then long write to a non-pending register
        do_reset();
        pipe_valid = 1; pipe_address = 0; pipe_data = 32'h1111_1111; pipe_strobe = 4'hf;
        long_valid = 1; long_address = 0; long_data = 32'h2222_2222; long_strobe = 4'hf;
        tick();
        pipe_valid = 0; long_valid = 0;
        tick();
        check_eq("z_we_pipe", rf_write_enabled, 0);
        tick();
        check_eq("z_we_long", rf_write_enabled, 0);
        tick();
        check_eq("z_pend", pending_count, 0);
        check_eq("z_err", scoreboard_error, 0);
        long_valid = 1; long_address = 12; long_data = 32'h0000_000C;
        tick();
        long_valid = 0;
        tick();
        check_eq("e_we12", rf_write_enabled, 1);
        check_eq("e_err_pre", scoreboard_error, 0);
        tick();
        check_eq("e_err", scoreboard_error, SB);
        check_eq("e_pend", pending_count, 0);
        tick(); tick();
        check_eq("e_err_sticky", scoreboard_error, SB);

        // Reset mid-operation: both buffers full, two pending
        issue_valid = 1; issue_address = 10;
        tick();
        issue_address = 11;
        tick();
        issue_valid = 0;
        #1;
        check_eq("mr_pend2", pending_count, SB ? 2 : 0);
        pipe_valid = 1; pipe_address = 3; pipe_data = 32'h3333_3333;
        long_valid = 1; long_address = 4; long_data = 32'h4444_4444;
        tick();
        check_eq("mr_pready", pipe_ready, 1);
        check_eq("mr_lready", long_ready, 0);
        pipe_valid = 0; long_valid = 0;
        resetn = 0;
        tick();
        resetn = 1;
        query_address_1 = 10; query_address_2 = 11;
        #1;
        check_eq("mr_we",    rf_write_enabled, 0);
        check_eq("mr_addr",  rf_write_address, 0);
        check_eq("mr_strb",  rf_write_strobe, 0);
        check_eq("mr_data",  rf_write_data, 0);
        check_eq("mr_pend",  pending_count, 0);
        check_eq("mr_err",   scoreboard_error, 0);
        check_eq("mr_pr",    pipe_ready, 1);
        check_eq("mr_lr",    long_ready, 1);
        check_eq("mr_qb1",   query_busy_1, 0);
        check_eq("mr_qb2",   query_busy_2, 0);
        tick();
        check_eq("mr_we_after", rf_write_enabled, 0);
        tick();
        check_eq("mr_we_after2", rf_write_enabled, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the register file's single write port between the in-order writeback stage and the long-latency (multiply/divide) unit. Holds one pending write per requester, arbitrates round-robin, and drives a registered write port into the register file. Also keeps a per-register scoreboard of outstanding long-latency destinations so decode can stall on read-after-write hazards.

## Interface
- MAX_PENDING, default 4: maximum outstanding long-latency destinations; range 1..7.

- clock  in  1  sole clock, rising edge
- resetn  in  1  synchronous, active-low reset
- pipe_valid / pipe_ready  in / out  1 / 1  writeback-stage write handshake
- pipe_address, pipe_strobe, pipe_data  in  5, 4, 32  writeback destination, byte strobe, data
- long_valid / long_ready  in / out  1 / 1  long-latency unit write handshake
- long_address, long_strobe, long_data  in  5, 4, 32  long-latency destination, strobe, data
- issue_valid  in  1  decode issues a long-latency op this cycle
- issue_address  in  5  destination of the issued op
- issue_accept  out  1  combinational; issue is recorded only when issue_valid && issue_accept
- query_address_1, query_address_2  in  5  decode source operands
- query_busy_1, query_busy_2  out  1  combinational; source has a pending long-latency write
- rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data  out  1, 5, 4, 32  registered register file write port
- pending_count  out  3  number of scoreboard entries set
- scoreboard_error  out  1  sticky; long write to a non-pending register

## Operation
- One single-entry buffer per requester. ready = buffer empty, or buffer granted this cycle. Transfer on valid && ready at the rising edge.
- Arbiter (combinational on buffer state): one buffer granted per cycle.
  - Only one full: that buffer wins.
  - Both full: the one not granted last time wins.
  - last_grant flag resets to "long", so pipe wins the first tie.
- Granted entry loads rf_write_* plus a src_long bit at the edge. With no grant, rf_write_enabled = 0 and the other fields hold their values.
- Address 0 entries: accepted and granted normally, but rf_write_enabled stays 0; a long entry to 0 does not touch the scoreboard.
- Scoreboard busy[31:1]:
  - Set: issue_valid && issue_accept && issue_address != 0 sets busy[issue_address] and increments pending_count.
  - issue_accept = 0 when issue_address != 0 and either busy[issue_address] is set (registered value, even if clearing this cycle) or pending_count == MAX_PENDING.
  - issue_accept = 1 for address 0; nothing is recorded.
  - Clear: busy[rf_write_address] clears and pending_count decrements at the edge where registered rf_write_enabled && src_long. This is the same edge the register file commits the write.
  - If that bit was already 0: scoreboard_error sets and pending_count is unchanged.
  - Set and clear of different registers on the same edge: both apply, and the count is unchanged.
- query_busy_n = busy[query_address_n]; always 0 for address 0.

## Timing
- Reset (resetn = 0 at an edge):
  - Buffers emptied; busy cleared; last_grant = long.
  - rf_write_enabled = 0, rf_write_address = 0, rf_write_strobe = 0, rf_write_data = 0.
  - pending_count = 0, scoreboard_error = 0.
  - pipe_ready = long_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards buffered writes and all pending entries.
- Latency, with acceptance at edge t0:
  - Uncontended entry loads rf_write_* at t0+1; the register file commits at t0+2.
  - Contended entry loads at t0+2.
  - Busy clears at the commit edge, so a query_busy low in a cycle guarantees a combinational register file read sees the new value.
- Throughput: 1 write/cycle total. A single requester streams at 1/cycle. Both streaming alternate, 1 per 2 cycles each; worst-case wait is one cycle.

## Configuration
- REGFILE_SCOREBOARD_EN:
  - Defined: scoreboard logic as above.
  - Undefined: no busy bits; issue_accept = 1, query_busy_1/2 = 0, pending_count = 0, scoreboard_error = 0. Write arbitration is unchanged.

## Test plan
- Reset, then pipe writes addr 5, strobe 4'b1111, data 32'h1234_5678 -> rf_write_enabled = 1 with those values exactly one cycle after acceptance; pipe_ready stays 1.
- Pipe and long both valid every cycle (addr 3 / addr 7) -> rf_write alternates pipe, long, pipe...; pipe is first after reset; each ready toggles 1, 0.
- Issue addr 9 -> query_busy_1 (addr 9) = 1, pending_count = 1. Long write addr 9 -> busy clears on the edge rf_write_enabled is sampled; pending_count = 0.
- Issue addrs 1..4 with MAX_PENDING = 4 -> fifth issue (addr 6) has issue_accept = 0; re-issue of addr 2 also has issue_accept = 0.
- Long write to addr 0 and pipe write to addr 0 -> rf_write_enabled stays 0, scoreboard unchanged. Long write to non-pending addr 12 -> scoreboard_error = 1 and stays 1 until reset.
- Assert resetn low with both buffers full and 2 pending -> next cycle all outputs at reset values and both readies are 1.
